m4_rr_arbiter: RTL

Round-robin arbiter that shares the 32-bit 4:1 operand/result mux between four requesters. It grants one requester at a time and drives the mux select. A grant is held until the target signals completion, the owner withdraws, or a hold limit expires. It sits beside the mux: `sel` connects directly to the mux's 2-bit select, and `gnt` goes back to the requesters.

---
 rtl/m4_rr_arbiter_pkg.sv | 23 ++
 rtl/m4_rr_arbiter_rr_pick4.sv | 19 +
 rtl/m4_rr_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/m4_rr_arbiter_pkg.sv
// Shared types and helpers for the 4-way round-robin mux arbiter.
package m4_rr_arbiter_pkg;

  localparam int NREQ = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Returns {found, idx}. Searches ptr, ptr+1, ... with wrap; the lowest offset from ptr wins.
  function automatic logic [2:0] rr_pick(input logic [NREQ-1:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    logic [2:0] res;
    res = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

endpackage

// File: rtl/m4_rr_arbiter_rr_pick4.sv
// Combinational rotating priority encoder: first set request at or after ptr.
module rr_pick4
  import m4_rr_arbiter_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      ptr,
  output logic            found,
  output logic [1:0]      idx
);

  logic [2:0] w_pick;

  always_comb begin
    w_pick = rr_pick(req, ptr);
    found  = w_pick[2];
    idx    = w_pick[1:0];
  end

endmodule

// File: rtl/m4_rr_arbiter.sv
// Round-robin arbiter for the shared 32-bit 4:1 operand/result mux.
// Grants one owner at a time; releases on done, owner withdrawal, or hold limit.
//
// state | meaning
// IDLE  | no owner, gnt=0; picks next requester from ptr
// BUSY  | owner holds the mux; counts hold cycles until a release
module m4_rr_arbiter
  import m4_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  output logic [NREQ-1:0] gnt,
  output logic [1:0]      sel,
  output logic            busy,
  output logic            timeout
);

  arb_state_e       r_state, w_state_nxt;
  logic [1:0]       r_own, w_own_nxt;
  logic [1:0]       r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [NREQ-1:0]  r_gnt, w_gnt_nxt;
  logic [1:0]       r_sel, w_sel_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_timeout, w_timeout_nxt;

  logic             w_found;
  logic [1:0]       w_idx;
  logic             w_rel_done, w_rel_drop, w_rel_term;

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (r_ptr),
    .found (w_found),
    .idx   (w_idx)
  );

  assign w_rel_done = done;
  assign w_rel_drop = ~req[r_own];
  assign w_rel_term = (r_cnt == CNT_W'(MAX_HOLD - 1));

  always_comb begin
    w_state_nxt   = r_state;
    w_own_nxt     = r_own;
    w_ptr_nxt     = r_ptr;
    w_cnt_nxt     = r_cnt;
    w_gnt_nxt     = r_gnt;
    w_sel_nxt     = r_sel;
    w_busy_nxt    = r_busy;
    w_timeout_nxt = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = BUSY;
          w_own_nxt   = w_idx;
          w_sel_nxt   = w_idx;
          w_gnt_nxt   = NREQ'(1) << w_idx;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b1;
        end
      end
      BUSY: begin
        if (w_rel_done || w_rel_drop || w_rel_term) begin
          w_state_nxt   = IDLE;
          w_gnt_nxt     = '0;
          w_busy_nxt    = 1'b0;
          w_ptr_nxt     = r_own + 2'd1;
          // Only a pure hold-limit release counts as a timeout.
          w_timeout_nxt = w_rel_term && !w_rel_done && !w_rel_drop;
        end else begin
          w_cnt_nxt = w_rel_term ? r_cnt : r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_own     <= '0;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_gnt     <= '0;
      r_sel     <= '0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_own     <= w_own_nxt;
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_gnt     <= w_gnt_nxt;
      r_sel     <= w_sel_nxt;
      r_busy    <= w_busy_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign gnt     = r_gnt;
  assign sel     = r_sel;
  assign busy    = r_busy;
  assign timeout = r_timeout;

endmodule
